dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Word-addressed data-memory responder that serves load/store requests from the CPU datapath over a valid/ready request channel and a valid/ready response channel.
It adds a configurable access latency so the core can be tested against non-ideal memory.
It sits between the CPU's memory-access stage and the storage array, replacing the zero-latency data memory in multi-cycle builds.
Out-of-range accesses are flagged rather than silently aliased.

Parameters:
DATA_WIDTH, 32, data word width in bits
DEPTH, 256, number of words in the storage array
WAIT_CYCLES, 2, extra clock edges between request acceptance and response (0 allowed, max 15)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  32  word address (not byte address)
req_wdata  input  DATA_WIDTH  store data
resp_valid  output  1  response available
resp_ready  input  1  initiator accepts the response
resp_rdata  output  DATA_WIDTH  load data; zero for stores and errors
resp_err  output  1  address was out of range (req_addr >= DEPTH)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, latency counter=0. Storage contents are NOT cleared; they are undefined until written.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept edge E0 = rising edge with req_valid&&req_ready. At E0, latch write flag, address and wdata.
  - If WAIT_CYCLES=0: go to RESP at E0 and perform the access at E0.
  - Otherwise: load counter=WAIT_CYCLES and go to WAIT.
- WAIT:
  - req_ready=0; req_valid is ignored.
  - Each edge: if counter==1, perform the access and go to RESP; else decrement the counter.
  - resp_valid first rises after edge E0+WAIT_CYCLES.
- Access at the edge entering RESP:
  - In range, store: mem[addr] <= wdata; resp_rdata=0; resp_err=0.
  - In range, load: resp_rdata <= mem[addr]; resp_err=0.
  - Out of range: no storage write; resp_rdata=0; resp_err=1.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until an edge with resp_ready=1.
  - On that edge: go to IDLE, resp_valid=0.
  - req_ready=0 throughout RESP. Minimum spacing between accepts is therefore WAIT_CYCLES+2 edges (resp_ready held high).
- Read-after-write:
  - A load following a store to the same address returns the new data.
  - No internal bypass is needed, since the store commits before the load is accepted.
- Address compare uses all 32 bits of req_addr; there is no wrap-around or aliasing.
- Reset asserted in WAIT: the transaction is aborted and no storage write is committed.
- Reset asserted in RESP: the response is dropped; a store already committed stays committed.
- Simultaneous resp_ready and a new req_valid in RESP: complete the response only; the request is accepted no earlier than the following edge in IDLE.
- req_addr, req_wdata and req_write may change freely after E0 without affecting the transaction.

Test Plan:
1. Reset, then idle 3 cycles -> req_ready=1, resp_valid=0, busy=0, resp_err=0, resp_rdata=0.
2. WAIT_CYCLES=2: store 0xDEADBEEF to addr 5, then load addr 5 (resp_ready=1) -> store response resp_valid after E0+2 with rdata=0; load returns 0xDEADBEEF after its E0+2; busy high from E0 to response edge.
3. Load addr 256 (DEPTH=256) -> resp_err=1, rdata=0. Then load addr 0 (previously written 0x1) -> 0x1, confirming no aliasing or corruption.
4. Hold resp_ready=0 for 5 cycles in RESP with req_valid=1 and a new request -> resp_valid and resp_rdata stable; req_ready=0; new request accepted only after the response edge.
5. Store 0x12345678 to addr 9, assert reset during WAIT, then load addr 9 -> original value (0x0 pre-written) returned; all outputs at reset values immediately on reset assert.
6. Rebuild with WAIT_CYCLES=0: store then load addr 3 value 0xA5A5A5A5 -> resp_valid high after the accept edge itself; load returns 0xA5A5A5A5; accept spacing is 2 edges.

Source files
------------

// File: rtl/dmem_if.sv
// dmem_if: request/response channel between the CPU memory stage and the
// data-memory responder.
//   req_valid/req_ready : request handshake (initiator -> responder)
//   req_write           : 1 = store, 0 = load
//   req_addr            : word address, all 32 bits are significant
//   req_wdata           : store data
//   resp_valid/resp_ready : response handshake (responder -> initiator)
//   resp_rdata          : load data, zero for stores and errors
//   resp_err            : address was out of range
// master = initiator (CPU side), slave = responder (memory side).
interface dmem_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory with a configurable access
// latency, served over valid/ready request and response channels.
// Out-of-range addresses are reported through resp_err instead of aliasing.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : asynchronous active-high reset (synchronous release)
//   bus   : dmem_if slave modport carrying both handshake channels
//   busy  : high whenever a transaction is in flight (state != IDLE)
// Parameters:
//   DATA_WIDTH  : word width in bits
//   DEPTH       : number of words in the storage array
//   WAIT_CYCLES : extra edges between accept and response (0..15)
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic    clk,
  input  logic    reset,
  dmem_if.slave   bus,
  output logic    busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] DEPTH_W = 33'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            count;
  logic                  write_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc_fire;
  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_in_range;
  logic [AW-1:0]         acc_idx;

  // With zero wait cycles the access happens on the accept edge itself, so
  // it must use the live request fields; otherwise it uses the latched copy.
  // Reset gates the fire so an aborted or reset-time request never commits.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_fire  = !reset && (state == S_IDLE) && bus.req_valid;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_fire  = !reset && (state == S_WAIT) && (count == 4'd1);
    end
    // Full 32-bit compare: no wrap-around of high address bits.
    acc_in_range = ({1'b0, acc_addr} < DEPTH_W);
    acc_idx      = acc_addr[AW-1:0];
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = (state != S_IDLE);

  // Storage array has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (acc_fire && acc_in_range && acc_write) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // Control FSM plus response registers. The response data is captured on
  // the edge that enters RESP and then held until the response handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              count <= 4'(WAIT_CYCLES);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (count == 4'd1) begin
            count <= 4'd0;
            state <= S_RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (acc_fire) begin
        rdata_q <= (acc_in_range && !acc_write) ? mem[acc_idx] : '0;
        err_q   <= !acc_in_range;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder.
// The stimulus side pushes the expected response for each accepted request
// (computed from an associative-array memory model); an independent monitor
// pops and compares whenever the responder presents a response.
module tb_dmem_responder;

  localparam int DW          = 32;
  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cycle;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  dmem_if #(.DATA_WIDTH(DW)) bus ();

  dmem_responder #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] ref_mem [int unsigned];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          ready_mode = 0;
  int          last_accept = -1;
  bit          in_resp = 1'b0;

  // Edge counter: sampled on the falling edge it equals the number of the
  // most recent rising edge.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d",
               name, act, exp, cycle);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=event at cycle %0d", name, cycle);
  endtask

  // Reference model: plain memory semantics, errors for addr >= DEPTH.
  function automatic exp_t model(input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata);
    exp_t e;
    e.acc_cycle = 0;
    if (addr >= 32'(DEPTH)) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
    end else if (wr) begin
      ref_mem[addr] = wdata;
      e.rdata = 32'h0;
      e.err   = 1'b0;
    end else begin
      e.rdata = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
      e.err   = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return 32'd255;
      1:       return 32'd256;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd256 + 32'($urandom_range(0, 15));
      default: return 32'($urandom_range(0, 15));
    endcase
  endfunction

  // resp_ready driver: 0 = random, 1 = always high, 2 = held low.
  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        1:       bus.resp_ready = 1'b1;
        2:       bus.resp_ready = 1'b0;
        default: bus.resp_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: pops on the first cycle of each response, then checks that the
  // response is held stable for as long as it stays valid.
  always @(negedge clk) begin
    if (!reset) begin
      check_output("ready_vs_busy", 32'(bus.req_ready), 32'(!busy));
      if (bus.resp_valid) begin
        check_output("ready_in_resp", 32'(bus.req_ready), 32'd0);
        if (!in_resp) begin
          in_resp = 1'b1;
          if (exp_q.size() == 0) begin
            report_timeout("unexpected_response");
          end else begin
            cur = exp_q.pop_front();
            check_output("latency", 32'(cycle - cur.acc_cycle), 32'(WAIT_CYCLES));
            check_output("rdata", bus.resp_rdata, cur.rdata);
            check_output("err", 32'(bus.resp_err), 32'(cur.err));
          end
        end else begin
          check_output("rdata_stable", bus.resp_rdata, cur.rdata);
          check_output("err_stable", 32'(bus.resp_err), 32'(cur.err));
        end
      end else begin
        in_resp = 1'b0;
      end
    end
  end

  // Issue one request; called and returns on a falling edge.
  task automatic apply_stimulus(input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit spacing_check);
    exp_t e;
    int   n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      report_timeout("accept_wait");
      bus.req_valid = 1'b0;
      return;
    end
    e = model(wr, addr, wdata);
    e.acc_cycle = cycle + 1;
    if (spacing_check && last_accept >= 0) begin
      check_output("accept_spacing", 32'(e.acc_cycle - last_accept), 32'(WAIT_CYCLES + 2));
    end
    last_accept = e.acc_cycle;
    exp_q.push_back(e);
    @(negedge clk);
    check_output("busy_after_accept", 32'(busy), 32'd1);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_write = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.resp_valid || !bus.req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) report_timeout("wait_idle");
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset.
    repeat (3) @(negedge clk);
    check_output("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_output("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check_output("rst_resp_rdata", bus.resp_rdata, 32'd0);

    // Give every address the bench may load a known value.
    ready_mode = 1;
    for (int a = 0; a < 16; a++) apply_stimulus(1'b1, 32'(a), $urandom, 1'b0);
    apply_stimulus(1'b1, 32'd255, 32'h0FF0_0FF0, 1'b0);
    apply_stimulus(1'b1, 32'd9, 32'h0, 1'b0);

    // Store then load the same address.
    apply_stimulus(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
    apply_stimulus(1'b0, 32'd5, 32'h0, 1'b0);

    // Out of range, aliasing candidates and the top in-range word.
    apply_stimulus(1'b1, 32'd0, 32'h1, 1'b0);
    apply_stimulus(1'b0, 32'd256, 32'h0, 1'b0);
    apply_stimulus(1'b1, 32'd261, 32'h5555_AAAA, 1'b0);
    apply_stimulus(1'b1, 32'hFFFF_FFFF, 32'h7777_7777, 1'b0);
    apply_stimulus(1'b0, 32'd0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 32'd5, 32'h0, 1'b0);
    apply_stimulus(1'b0, 32'd255, 32'h0, 1'b0);

    // Response held back while a new request waits.
    wait_idle();
    ready_mode = 2;
    apply_stimulus(1'b0, 32'd5, 32'h0, 1'b0);
    fork
      apply_stimulus(1'b1, 32'd7, 32'hCAFE_F00D, 1'b0);
      begin
        int n = 0;
        while (!bus.resp_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (!bus.resp_valid) report_timeout("hold_resp_wait");
        repeat (5) @(negedge clk);
        check_output("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
        check_output("hold_req_ready", 32'(bus.req_ready), 32'd0);
        ready_mode = 1;
      end
    join
    apply_stimulus(1'b0, 32'd7, 32'h0, 1'b0);

    // Reset in the middle of a store aborts it.
    wait_idle();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'd9;
    bus.req_wdata = 32'h1234_5678;
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_output("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check_output("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_resp_err", 32'(bus.resp_err), 32'd0);
    check_output("abort_resp_rdata", bus.resp_rdata, 32'd0);
    if (WAIT_CYCLES == 0) ref_mem[32'd9] = 32'h1234_5678;
    @(negedge clk);
    exp_q.delete();
    in_resp = 1'b0;
    reset = 1'b0;
    apply_stimulus(1'b0, 32'd9, 32'h0, 1'b0);

    // Back-to-back accepts with resp_ready held high.
    wait_idle();
    last_accept = -1;
    apply_stimulus(1'b1, 32'd3, 32'hA5A5_A5A5, 1'b1);
    apply_stimulus(1'b0, 32'd3, 32'h0, 1'b1);
    apply_stimulus(1'b0, 32'd3, 32'h0, 1'b1);

    // Randomized traffic with random response back-pressure and gaps.
    wait_idle();
    ready_mode = 0;
    for (int i = 0; i < 60; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), pick_addr(), $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    ready_mode = 1;
    wait_idle();
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
